// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and defaults for the FIFO read-side packet reader.
//   fpr_state_t  : reader FSM state (IDLE, RUN, FINISH)
//   FPR_DATASIZE : default FIFO word width
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } fpr_state_t;

    localparam int FPR_DATASIZE = 8;

endpackage

// File: rtl/fifo_skid_buffer.sv
// -----------------------------------------------------------------------------
// fifo_skid_buffer
// Two-entry registered buffer. The output always shows the oldest entry.
// A push and a pop in the same cycle leave the occupancy unchanged.
// A push into a full buffer is accepted only together with a pop.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_push     write i_data
//   i_data     entry to store
//   i_pop      remove the oldest entry (ignored when empty)
//   o_data     oldest entry
//   o_occ      number of stored entries, 0..2
// -----------------------------------------------------------------------------
module fifo_skid_buffer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_entry0;
    logic [WIDTH-1:0] r_entry1;
    logic [1:0]       r_occ;

    logic [WIDTH-1:0] w_entry0_next;
    logic [WIDTH-1:0] w_entry1_next;
    logic [1:0]       w_occ_next;
    logic             w_pop;

    assign w_pop = i_pop & (r_occ != 2'd0);

    always_comb begin
        w_entry0_next = r_entry0;
        w_entry1_next = r_entry1;
        w_occ_next    = r_occ;
        case (r_occ)
            2'd0: begin
                if (i_push) begin
                    w_entry0_next = i_data;
                    w_occ_next    = 2'd1;
                end
            end
            2'd1: begin
                if (i_push && w_pop) begin
                    w_entry0_next = i_data;
                end else if (i_push) begin
                    w_entry1_next = i_data;
                    w_occ_next    = 2'd2;
                end else if (w_pop) begin
                    w_occ_next    = 2'd0;
                end
            end
            2'd2: begin
                if (w_pop) begin
                    // Second entry moves to the head; a simultaneous push refills the tail.
                    w_entry0_next = r_entry1;
                    if (i_push) begin
                        w_entry1_next = i_data;
                    end else begin
                        w_occ_next    = 2'd1;
                    end
                end
            end
            default: begin
                w_occ_next = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_occ    <= 2'd0;
        end else begin
            r_entry0 <= w_entry0_next;
            r_entry1 <= w_entry1_next;
            r_occ    <= w_occ_next;
        end
    end

    assign o_data = r_entry0;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_packet_reader.sv
// -----------------------------------------------------------------------------
// fifo_packet_reader
// Pops words from a show-ahead FIFO read port and presents them as a
// valid/ready stream at up to one word per cycle. Every PKT_LEN-th word is
// tagged with m_last. Dropping enable lets the open packet complete before
// returning to IDLE.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   enable        run request; 1->0 stops at the next packet boundary
//   fifo_empty    FIFO empty flag
//   fifo_rdata    FIFO head word
//   fifo_r_en     FIFO pop (combinational)
//   m_valid/m_ready/m_data/m_last  output stream
//   pkt_count     completed packets (wraps)
//   busy          FSM active or words still buffered
// -----------------------------------------------------------------------------
module fifo_packet_reader
    import fifo_pkg::*;
#(
    parameter int DATASIZE = FPR_DATASIZE,
    parameter int PKT_LEN  = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                fifo_empty,
    input  logic [DATASIZE-1:0] fifo_rdata,
    output logic                fifo_r_en,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data,
    output logic                m_last,
    output logic [CNT_W-1:0]    pkt_count,
    output logic                busy
);

    localparam int                IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_LEN - 1);

    fpr_state_t         r_state;
    fpr_state_t         w_state_next;
    logic [IDX_W-1:0]   r_word_idx;
    logic [CNT_W-1:0]   r_pkt_count;

    logic               w_fetch_ok;
    logic               w_pop_fifo;
    logic               w_word_last;
    logic               w_valid;
    logic               w_xfer;
    logic [1:0]         w_occ;
    logic [DATASIZE:0]  w_buf_out;

    // In FINISH, fetching continues only to complete a partially read packet.
    assign w_fetch_ok  = (r_state == RUN) | ((r_state == FINISH) & (r_word_idx != '0));
    // rst gates the pop so the FIFO never loses a word the buffer cannot keep.
    assign w_pop_fifo  = w_fetch_ok & ~fifo_empty & (w_occ < 2'd2) & ~rst;
    assign w_word_last = (r_word_idx == LAST_IDX);
    assign w_valid     = (w_occ != 2'd0);
    assign w_xfer      = w_valid & m_ready;

    fifo_skid_buffer #(
        .WIDTH (DATASIZE + 1)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_pop_fifo),
        .i_data ({w_word_last, fifo_rdata}),
        .i_pop  (w_xfer),
        .o_data (w_buf_out),
        .o_occ  (w_occ)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_state_next = RUN;
            end
            RUN: begin
                if (!enable) w_state_next = FINISH;
            end
            FINISH: begin
                if (enable) begin
                    w_state_next = RUN;
                end else if ((r_word_idx == '0) && (w_occ == 2'd0)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_word_idx  <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop_fifo) begin
                r_word_idx <= w_word_last ? '0 : r_word_idx + 1'b1;
            end
            if (w_xfer && w_buf_out[DATASIZE]) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
        end
    end

    assign fifo_r_en = w_pop_fifo;
    assign m_valid   = w_valid;
    assign m_data    = w_buf_out[DATASIZE-1:0];
    assign m_last    = w_buf_out[DATASIZE] & w_valid;
    assign pkt_count = r_pkt_count;
    assign busy      = (r_state != IDLE) | w_valid;

endmodule

// File: tb/tb_fifo_packet_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_packet_reader
// Bench for fifo_packet_reader: a modelled show-ahead FIFO feeds the reader,
// loaded words are queued as expected {last,data} beats and compared as the
// stream delivers them.
// -----------------------------------------------------------------------------
module tb_fifo_packet_reader;

    localparam int PKT_LEN = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_r_en;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] pkt_count;
    logic        busy;

    fifo_packet_reader #(
        .DATASIZE (8),
        .PKT_LEN  (PKT_LEN),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .pkt_count  (pkt_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model
    logic [7:0]  fifo_mem [256];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    int unsigned pop_cnt = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = fifo_mem[rd_ptr[7:0]];

    // Reset flushes the modelled FIFO so every test starts clean.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_r_en) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    // Scoreboard
    logic [8:0]  exp_q [$];
    int          exp_idx   = 0;
    int          pkt_model = 0;
    int          n_tests   = 0;
    int          n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d, input bit expect_it);
        fifo_mem[wr_ptr[7:0]] = d;
        wr_ptr++;
        if (expect_it) begin
            exp_q.push_back({(exp_idx == PKT_LEN - 1), d});
            exp_idx = (exp_idx + 1) % PKT_LEN;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        check(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_r_en) check("no_pop_when_empty", {31'd0, fifo_empty}, 0);
            if (m_valid && m_ready) begin
                check("beat_expected", {31'd0, (exp_q.size() != 0)}, 1);
                if (exp_q.size() != 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("beat_data", {24'd0, m_data}, {24'd0, e[7:0]});
                    check("beat_last", {31'd0, m_last}, {31'd0, e[8]});
                    $display("[TB] beat data=0x%02h last=%0d", m_data, m_last);
                    if (e[8]) pkt_model++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst     = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_m_valid",   {31'd0, m_valid},   0);
        check("rst_m_last",    {31'd0, m_last},    0);
        check("rst_m_data",    {24'd0, m_data},    0);
        check("rst_busy",      {31'd0, busy},      0);
        check("rst_pkt_count", {16'd0, pkt_count}, 0);
        check("rst_fifo_r_en", {31'd0, fifo_r_en}, 0);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) load(8'h10 + 8'(i), 1'b1);
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 10 && !fifo_r_en; i++) step();
        check("t2_first_pop",  {31'd0, fifo_r_en}, 1);
        check("t2_pre_valid",  {31'd0, m_valid},   0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t2_beat_valid", {31'd0, m_valid}, 1);
        end
        drain("t2_drain");
        step();
        check("t2_pkt_count", {16'd0, pkt_count}, 2);
        enable = 1'b0;
        repeat (3) step();
        check("t2_idle_busy", {31'd0, busy}, 0);

        // Backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(8'h20 + 8'(i), 1'b1);
        enable = 1'b1;
        p0 = pop_cnt;
        repeat (7) step();
        check("t3_pops",      pop_cnt - p0, 2);
        check("t3_r_en_low",  {31'd0, fifo_r_en}, 0);
        check("t3_valid",     {31'd0, m_valid}, 1);
        check("t3_held_data", {24'd0, m_data}, {24'd0, exp_q[0][7:0]});
        m_ready = 1'b1;
        drain("t3_drain");
        step();
        check("t3_pkt_count", {16'd0, pkt_count}, pkt_model);

        // Graceful stop mid-packet
        load(8'h30, 1'b1);
        load(8'h31, 1'b1);
        repeat (4) step();
        enable = 1'b0;
        p0 = pop_cnt;
        repeat (11) step();
        check("t4_busy_wait", {31'd0, busy},      1);
        check("t4_no_pop",    {31'd0, fifo_r_en}, 0);
        load(8'h32, 1'b1);
        load(8'h33, 1'b1);
        drain("t4_drain");
        repeat (3) step();
        check("t4_idle_busy", {31'd0, busy}, 0);
        check("t4_pkt_count", {16'd0, pkt_count}, pkt_model);
        load(8'h40, 1'b0);
        load(8'h41, 1'b0);
        p0 = pop_cnt;
        repeat (5) step();
        check("t4_idle_pops",  pop_cnt - p0, 0);
        check("t4_idle_r_en",  {31'd0, fifo_r_en}, 0);

        // Reset mid-traffic
        m_ready = 1'b0;
        enable  = 1'b1;
        for (int i = 0; i < 4; i++) load(8'h48 + 8'(i), 1'b0);
        repeat (4) step();
        rst = 1'b1;
        exp_q.delete();
        exp_idx   = 0;
        pkt_model = 0;
        #1;
        check("t1_m_valid",   {31'd0, m_valid},   0);
        check("t1_fifo_r_en", {31'd0, fifo_r_en}, 0);
        check("t1_pkt_count", {16'd0, pkt_count}, 0);
        check("t1_busy",      {31'd0, busy},      0);
        enable = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Enabled on an empty FIFO
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t5_r_en",  {31'd0, fifo_r_en}, 0);
            check("t5_valid", {31'd0, m_valid},   0);
        end

        // Reset partway through a packet restarts framing
        for (int i = 0; i < 3; i++) load(8'h50 + 8'(i), 1'b1);
        drain("t6_pre_drain");
        step();
        rst = 1'b1;
        exp_q.delete();
        exp_idx   = 0;
        pkt_model = 0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) load(8'h60 + 8'(i), 1'b1);
        drain("t6_drain");
        step();
        check("t6_pkt_count", {16'd0, pkt_count}, 1);

        check("final_sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
